// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX sequencer and the future RX block.
//   tx_state_e      : transmit sequencer states
//   parity_mode_e   : parity mode encoding (none / even / odd)
//   UART_OVERSAMPLE : default ticks per bit
//   calc_parity     : parity bit of a data word for a given mode
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_e;

  // XOR of the data, inverted for odd parity. Narrow words are zero-extended.
  function automatic logic calc_parity(logic [7:0] d, parity_mode_e mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake, frame config, tick strobe and serial/status outputs of the
// UART transmit sequencer.
//   master : the FIFO/baud side that supplies bytes, config and ticks
//   slave  : the transmit sequencer
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick_i;
  logic [DATA_BITS-1:0] data_i;
  logic                 valid_i;
  logic                 ready_o;
  logic                 parity_en_i;
  logic                 parity_odd_i;
  logic                 stop2_i;
  logic                 tx_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output tick_i, data_i, valid_i, parity_en_i, parity_odd_i, stop2_i,
    input  ready_o, tx_o, busy_o, done_o
  );

  modport slave (
    input  tick_i, data_i, valid_i, parity_en_i, parity_odd_i, stop2_i,
    output ready_o, tx_o, busy_o, done_o
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, DATA_BITS data bits LSB first, optional
// parity, one or two stop bits. Bit timing is OVERSAMPLE ticks of tick_i.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : slave side of uart_tx_ctrl_if (handshake, config, tx, status)
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_tx_ctrl_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TLAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  tx_state_e            state, state_d;
  logic [DATA_BITS-1:0] shreg;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  parity_mode_e         par_mode_q;
  logic                 par_bit;
  logic                 stop2_q;
  logic                 done_q, done_d;
  logic                 xfer, bit_end;
  parity_mode_e         par_mode_in;

  assign xfer        = bus.valid_i && (state == IDLE);
  assign bit_end     = bus.tick_i && (state != IDLE) && (tcnt == TLAST);
  assign par_mode_in = !bus.parity_en_i ? PAR_NONE :
                       (bus.parity_odd_i ? PAR_ODD : PAR_EVEN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    unique case (state)
      IDLE:   if (xfer) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && bcnt == BLAST)
                state_d = (par_mode_q != PAR_NONE) ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      // bcnt is reused to count stop bits; it is zero on entry to STOP.
      STOP:   if (bit_end && (!stop2_q || bcnt == BW'(1))) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg      <= '0;
      tcnt       <= '0;
      bcnt       <= '0;
      par_mode_q <= PAR_NONE;
      par_bit    <= 1'b0;
      stop2_q    <= 1'b0;
    end else if (xfer) begin
      shreg      <= bus.data_i;
      tcnt       <= '0;
      bcnt       <= '0;
      par_mode_q <= par_mode_in;
      par_bit    <= calc_parity(8'(bus.data_i), par_mode_in);
      stop2_q    <= bus.stop2_i;
    end else if (bus.tick_i && state != IDLE) begin
      tcnt <= bit_end ? '0 : tcnt + TW'(1);
      if (bit_end) begin
        if (state == DATA) begin
          shreg <= shreg >> 1;
          bcnt  <= (bcnt == BLAST) ? '0 : bcnt + BW'(1);
        end else if (state == STOP) begin
          bcnt  <= bcnt + BW'(1);
        end
      end
    end
  end

  always_comb begin
    bus.tx_o = 1'b1;
    unique case (state)
      START:   bus.tx_o = 1'b0;
      DATA:    bus.tx_o = shreg[0];
      PARITY:  bus.tx_o = par_bit;
      default: bus.tx_o = 1'b1;
    endcase
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.busy_o  = (state != IDLE);
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_BITS(8)) bus ();

  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_tx", bus.tx_o, 1);
    chk("idle_rdy", bus.ready_o, 1);
    chk("idle_done", bus.done_o, 0);
  endtask

  // Positioned 1 time unit after an edge with the block expected ready.
  // Reference: the frame is a list of line levels, each held for OS ticks.
  // Level in cycle k is bits[ticks seen in cycles 1..k-1 / OS]; once all
  // bits have elapsed, that cycle is the done cycle. Returns with the bench
  // sitting in the done cycle and valid_i low.
  task automatic send(input logic [7:0] d, input logic pen, input logic podd,
                      input logic s2, input int tmode, output int done_cyc);
    int  bits [12];
    int  nb, n;
    bit  fin;
    logic t;
    chk("rdy_pre", bus.ready_o, 1);
    nb = 0;
    bits[nb++] = 0;
    for (int i = 0; i < 8; i++) bits[nb++] = d[i];
    if (pen) bits[nb++] = (^d) ^ podd;
    bits[nb++] = 1;
    if (s2) bits[nb++] = 1;
    bus.data_i       = d;
    bus.parity_en_i  = pen;
    bus.parity_odd_i = podd;
    bus.stop2_i      = s2;
    bus.valid_i      = 1'b1;
    bus.tick_i       = 1'($urandom_range(0, 1));  // must not be counted
    n = 0; fin = 0; done_cyc = 0;
    @(posedge clk); #1;
    for (int c = 1; c <= 6000; c++) begin
      done_cyc = c;
      if (n / OS < nb) begin
        chk("tx", bus.tx_o, bits[n / OS]);
        chk("busy", bus.busy_o, 1);
        chk("rdy_busy", bus.ready_o, 0);
        chk("done_early", bus.done_o, 0);
      end else begin
        chk("done", bus.done_o, 1);
        chk("done_tx", bus.tx_o, 1);
        chk("done_busy", bus.busy_o, 0);
        chk("done_rdy", bus.ready_o, 1);
        bus.valid_i = 1'b0;
        fin = 1;
        break;
      end
      // Inputs other than the tick must not disturb a frame in flight.
      bus.valid_i      = 1'($urandom);
      bus.data_i       = 8'($urandom);
      bus.parity_en_i  = 1'($urandom);
      bus.parity_odd_i = 1'($urandom);
      bus.stop2_i      = 1'($urandom);
      case (tmode)
        0:       t = 1'b1;
        1:       t = (c % 4 == 0);
        default: t = 1'($urandom_range(0, 1));
      endcase
      bus.tick_i = t;
      if (t) n++;
      @(posedge clk); #1;
    end
    if (!fin) chk("timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.tick_i = 0; bus.data_i = 0; bus.valid_i = 0;
    bus.parity_en_i = 0; bus.parity_odd_i = 0; bus.stop2_i = 0;

    // Reset held with inputs toggling.
    for (int i = 0; i < 8; i++) begin
      bus.tick_i  = 1'($urandom); bus.valid_i = 1'($urandom);
      bus.data_i  = 8'($urandom); bus.stop2_i = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_tx", bus.tx_o, 1);
      chk("rst_rdy", bus.ready_o, 1);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
    end
    bus.valid_i = 0; bus.tick_i = 1;
    rst = 1'b0;
    // Ticks in idle are ignored.
    for (int i = 0; i < 3; i++) idle_cycle();

    send(8'hA5, 0, 0, 0, 0, cyc);
    chk("8n1_len", cyc, 161);
    idle_cycle();

    send(8'h03, 1, 1, 1, 0, cyc);
    chk("8o2_len", cyc, 193);
    idle_cycle();

    send(8'hA5, 0, 0, 0, 1, cyc);
    chk("sparse_len", ((cyc - 1) >= 637 && (cyc - 1) <= 643), 1);
    idle_cycle();

    // Back-to-back: second byte presented in the done cycle.
    send(8'h55, 0, 0, 0, 0, cyc);
    send(8'hAA, 1, 0, 1, 0, cyc);
    chk("b2b_len", cyc, 193);

    // Random frames, random gaps (gap 0 is back-to-back).
    for (int f = 0; f < 20; f++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) idle_cycle();
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2), cyc);
    end
    idle_cycle();

    // Mid-frame reset in cycle 50.
    bus.data_i = 8'hFF; bus.valid_i = 1; bus.tick_i = 1;
    bus.parity_en_i = 0; bus.stop2_i = 0;
    @(posedge clk); #1;
    bus.valid_i = 0;
    for (int c = 1; c < 50; c++) begin @(posedge clk); #1; end
    chk("mr_busy_before", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    chk("mr_tx", bus.tx_o, 1);
    chk("mr_rdy", bus.ready_o, 1);
    chk("mr_busy", bus.busy_o, 0);
    @(posedge clk); #1;
    chk("mr_done", bus.done_o, 0);
    rst = 1'b0;
    idle_cycle();
    send(8'h3C, 1, 0, 0, 0, cyc);
    chk("mr_after_len", cyc, 177);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit sequencer. Accepts a byte over a valid/ready handshake and serialises it onto `tx_o` as start bit, data bits LSB first, optional parity and one or two stop bits. Bit timing comes from an external 16× oversampling tick, normally the baud divider output; this block only counts ticks. Sits between the bus-side TX FIFO and the pad.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `OVERSAMPLE`, default 16: ticks per bit, legal range ≥ 2.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `tick_i`  in  1  one-cycle oversampling strobe.
- `data_i`  in  DATA_BITS  byte to send.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  block can accept a byte.
- `parity_en_i`  in  1  append a parity bit.
- `parity_odd_i`  in  1  1 = odd parity, 0 = even parity.
- `stop2_i`  in  1  1 = two stop bits, 0 = one stop bit.
- `tx_o`  out  1  serial line, idles high.
- `busy_o`  out  1  a frame is in progress.
- `done_o`  out  1  one-cycle pulse when a frame completes.

## Operation
- States:
  - `IDLE`: `tx_o`=1.
  - `START`: `tx_o`=0.
  - `DATA`: `tx_o`=`shreg[0]`.
  - `PARITY`: `tx_o`=parity bit.
  - `STOP`: `tx_o`=1.
- Handshake:
  - `ready_o` = (state==`IDLE`).
  - Transfer occurs on a rising edge with `valid_i && ready_o`.
  - On transfer, latch `data_i` into `shreg`, and latch `parity_en_i`, `parity_odd_i`, `stop2_i`.
  - Config-input changes mid-frame have no effect.
- Tick counter `tcnt` is $clog2(OVERSAMPLE) bits wide.
  - Cleared on transfer.
  - Increments only on `tick_i` in non-`IDLE` states.
  - A tick with `tcnt`==OVERSAMPLE−1 ends the current bit: `tcnt`→0 and the sequencer advances.
- Bit counter `bcnt` counts data bits 0..DATA_BITS−1. In `DATA`, each bit end shifts `shreg` right by one.
- Transitions:
  - `IDLE`→`START` on transfer.
  - `START`→`DATA` at bit end.
  - `DATA`→`DATA` while `bcnt`<DATA_BITS−1.
  - At the last data bit end, `DATA`→`PARITY` if parity is latched on, else `DATA`→`STOP`.
  - `PARITY`→`STOP` at bit end.
  - `STOP` lasts one bit, or two bits if two stop bits were latched; it then returns to `IDLE`.
- Parity = XOR of the latched data, inverted when odd parity is selected. It is computed at transfer and held in a flop.
- `busy_o` = (state≠`IDLE`).
- `done_o` is registered. It is high for exactly the first cycle in `IDLE` after `STOP`.

## Timing
- Reset values: `tx_o`=1, `ready_o`=1, `busy_o`=0, `done_o`=0, state=`IDLE`, counters=0.
- Reset is asynchronous. Asserted mid-frame, it forces `tx_o` high immediately and aborts the frame with no `done_o`.
- All outputs are registered or decoded from registered state.
- `tx_o` drops to 0 in the cycle after the transfer edge.
- Each bit lasts exactly OVERSAMPLE ticks.
- Frame length in ticks = OVERSAMPLE × (1 + DATA_BITS + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- A `tick_i` coincident with the transfer edge is not counted.
- `tick_i` in `IDLE` is ignored.
- Back-to-back frames:
  - `ready_o` rises in the same cycle as `done_o`.
  - A byte presented then is accepted at the next edge, so there is zero idle-bit gap beyond that one cycle.
- `valid_i` high while `ready_o` low: no transfer; `data_i` is not sampled.
- `tick_i` stuck high (tick every cycle) is legal. Each bit is then OVERSAMPLE cycles long.

## Structure
- Shared `uart_pkg` holds:
  - `tx_state_e` typedef (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`).
  - `UART_OVERSAMPLE` = 16, the default source for `OVERSAMPLE`.
  - The parity-mode encoding, reused by the future RX block.
- There is no sub-module. Tick and bit counters are inline; the block is a single FSM with its datapath.

## Test plan
Unless noted, `tick_i`=1 every cycle and cycle 1 is the first cycle after the transfer edge.
- **Reset:** hold `rst_i`=1, toggle inputs → `tx_o`=1, `ready_o`=1, `busy_o`=0, `done_o`=0 throughout.
- **8N1, `data_i`=0xA5:**
  - `tx_o` in cycles 1–16 is 0.
  - Data bits 1,0,1,0,0,1,0,1 follow, 16 cycles each, over cycles 17–144.
  - Stop bit is 1 over cycles 145–160.
  - `done_o` pulses in cycle 161; `busy_o` is 1 over cycles 1–160.
- **8O2, `data_i`=0x03:**
  - Parity bit over cycles 145–160 is 1 (popcount 2, odd parity).
  - Stop bits over cycles 161–192.
  - `done_o` pulses in cycle 193.
- **Sparse ticks:** `tick_i` every 4th cycle, 8N1 → start bit lasts 64 cycles; total frame is 640 cycles ±3.
- **Back-to-back:** `valid_i` held high with 0x55 then 0xAA.
  - Second transfer occurs on the edge ending the `done_o` cycle.
  - `tx_o` goes 0 in the following cycle.
  - Config changed during frame 1 takes effect only in frame 2.
- **Mid-frame reset:** assert `rst_i` in cycle 50 of a frame → `tx_o`=1 the same cycle and `ready_o`=1. After release, a new byte is transmitted correctly.
